// File: rtl/mux1hot_pkg.sv
// Shared types and helpers for the one-hot mux / round-robin stage.
package mux1hot_pkg;

   localparam int MAX_INPUTS = 32;

   function automatic int onehot_to_idx(input logic [MAX_INPUTS-1:0] v);
      int r;
      r = 0;
      for (int i = 0; i < MAX_INPUTS; i++)
         if (v[i]) r = r | i;
      return r;
   endfunction

   function automatic logic [MAX_INPUTS-1:0] rotate_left(
      input logic [MAX_INPUTS-1:0] v,
      input int                    sh,
      input int                    n
   );
      logic [MAX_INPUTS-1:0] r;
      r = '0;
      for (int i = 0; i < MAX_INPUTS; i++)
         if (i < n) r[(i + sh) % n] = v[i];
      return r;
   endfunction

endpackage

// File: rtl/Mux1hot.sv
// One-hot select data mux; sel must be one-hot or zero.
module Mux1hot #(
   parameter int INPUTS = 4,
   parameter int WIDTH  = 32
) (
   input  logic [INPUTS-1:0]       sel,
   input  logic [WIDTH*INPUTS-1:0] in_data,
   output logic [WIDTH-1:0]        out_data
);

   always_comb begin
      out_data = '0;
      for (int i = 0; i < INPUTS; i++)
         if (sel[i]) out_data = out_data | in_data[i*WIDTH +: WIDTH];
   end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter; optional packet lock via MUX1HOT_RR_STAGE_PKT_LOCK_EN.
module rr_arbiter
   import mux1hot_pkg::*;
#(
   parameter int INPUTS = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [INPUTS-1:0] req,
   input  logic              advance,
`ifdef MUX1HOT_RR_STAGE_PKT_LOCK_EN
   input  logic [INPUTS-1:0] last,
`endif
   output logic [INPUTS-1:0] grant,
   output logic [4:0]        ptr
);

   logic [INPUTS-1:0] rr_grant;
   int                k;
   int                nxt;

   always_comb begin
      logic found;
      int   idx;
      rr_grant = '0;
      found    = 1'b0;
      idx      = 0;
      for (int i = 0; i < INPUTS; i++) begin
         idx = (int'(ptr) + i) % INPUTS;
         if (!found && req[idx]) begin
            rr_grant[idx] = 1'b1;
            found         = 1'b1;
         end
      end
   end

   always_comb begin
      k   = onehot_to_idx(MAX_INPUTS'(grant));
      nxt = (k + 1 == INPUTS) ? 0 : k + 1;
   end

`ifdef MUX1HOT_RR_STAGE_PKT_LOCK_EN
   logic       locked;
   logic [4:0] lock_id;

   // A partially sent packet owns the grant until its last beat.
   always_comb begin
      if (locked)
         grant = req & (INPUTS'(1) << lock_id);
      else
         grant = rr_grant;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr     <= '0;
         locked  <= 1'b0;
         lock_id <= '0;
      end else if (advance) begin
         if (last[k]) begin
            locked <= 1'b0;
            ptr    <= 5'(nxt);
         end else begin
            locked  <= 1'b1;
            lock_id <= 5'(k);
         end
      end
   end
`else
   assign grant = rr_grant;

   always_ff @(posedge clk) begin
      if (!rst_n)
         ptr <= '0;
      else if (advance)
         ptr <= 5'(nxt);
   end
`endif

endmodule

// File: rtl/mux1hot_rr_stage.sv
// Round-robin valid/ready merge into a registered output stage.
// Optional packet lock: define MUX1HOT_RR_STAGE_PKT_LOCK_EN.
module mux1hot_rr_stage
   import mux1hot_pkg::*;
#(
   parameter int INPUTS = 4,
   parameter int WIDTH  = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [INPUTS-1:0]       in_valid,
   input  logic [WIDTH*INPUTS-1:0] in_data,
`ifdef MUX1HOT_RR_STAGE_PKT_LOCK_EN
   input  logic [INPUTS-1:0]       in_last,
   output logic                    out_last,
`endif
   output logic [INPUTS-1:0]       in_ready,
   output logic                    out_valid,
   output logic [WIDTH-1:0]        out_data,
   output logic [INPUTS-1:0]       out_sel,
   input  logic                    out_ready
);

   logic              load;
   logic              advance;
   logic [INPUTS-1:0] grant;
   logic [4:0]        ptr;
   logic [WIDTH-1:0]  mux_data;

   assign load     = !out_valid || out_ready;
   assign in_ready = grant & {INPUTS{load && rst_n}};
   assign advance  = |in_ready;

   rr_arbiter #(
      .INPUTS (INPUTS)
   ) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (in_valid),
      .advance (advance),
`ifdef MUX1HOT_RR_STAGE_PKT_LOCK_EN
      .last    (in_last),
`endif
      .grant   (grant),
      .ptr     (ptr)
   );

   Mux1hot #(
      .INPUTS (INPUTS),
      .WIDTH  (WIDTH)
   ) u_mux (
      .sel      (grant),
      .in_data  (in_data),
      .out_data (mux_data)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
`ifdef MUX1HOT_RR_STAGE_PKT_LOCK_EN
         out_last  <= 1'b0;
`endif
      end else if (load) begin
         out_valid <= |grant;
         if (|grant) begin
            out_data <= mux_data;
            out_sel  <= grant;
`ifdef MUX1HOT_RR_STAGE_PKT_LOCK_EN
            out_last <= |(in_last & grant);
`endif
         end
      end
   end

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (rst_n) begin
         assert ($onehot0(in_ready));
         assert ($onehot0(out_sel));
         assert (!out_valid || $onehot(out_sel));
         assert (int'(ptr) < INPUTS);
      end
   end
`endif

endmodule

// File: tb/tb_mux1hot_rr_stage.sv
// Directed table-driven bench for mux1hot_rr_stage (INPUTS=4, WIDTH=32).
module tb_mux1hot_rr_stage;

   logic         clk;
   logic         rst_n;
   logic [3:0]   in_valid;
   logic [127:0] in_data;
   logic [3:0]   in_ready;
   logic         out_valid;
   logic [31:0]  out_data;
   logic [3:0]   out_sel;
   logic         out_ready;
`ifdef MUX1HOT_RR_STAGE_PKT_LOCK_EN
   logic [3:0]   in_last;
   logic         out_last;
`endif

   int checks;
   int errors;

   mux1hot_rr_stage #(
      .INPUTS (4),
      .WIDTH  (32)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
`ifdef MUX1HOT_RR_STAGE_PKT_LOCK_EN
      .in_last   (in_last),
      .out_last  (out_last),
`endif
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        r;
      logic [3:0]  v;
      logic        rd;
      logic [3:0]  ir;
      logic        ov;
      logic [31:0] od;
      logic [3:0]  os;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input int row,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
      end
   endtask

   task automatic step(input int row, input vec_t t);
      rst_n     = t.r;
      in_valid  = t.v;
      out_ready = t.rd;
      #1;
      chk("in_ready", row, 32'(in_ready), 32'(t.ir));
      @(posedge clk);
      #1;
      chk("out_valid", row, 32'(out_valid), 32'(t.ov));
      chk("out_data", row, out_data, t.od);
      chk("out_sel", row, 32'(out_sel), 32'(t.os));
   endtask

   function automatic vec_t mk(logic r, logic [3:0] v, logic rd,
                               logic [3:0] ir, logic ov,
                               logic [31:0] od, logic [3:0] os);
      vec_t t;
      t.r = r; t.v = v; t.rd = rd;
      t.ir = ir; t.ov = ov; t.od = od; t.os = os;
      return t;
   endfunction

   initial begin
      checks = 0;
      errors = 0;
      rst_n     = 1'b0;
      in_valid  = '0;
      out_ready = 1'b0;
`ifdef MUX1HOT_RR_STAGE_PKT_LOCK_EN
      in_last   = 4'hF;
`endif
      for (int i = 0; i < 4; i++)
         in_data[i*32 +: 32] = 32'hA0 + 32'(i);

      // reset with all channels requesting
      for (int i = 0; i < 3; i++)
         tbl.push_back(mk(0, 4'hF, 1, 4'h0, 0, 32'h0, 4'h0));
      // fairness
      tbl.push_back(mk(1, 4'hF, 1, 4'b0001, 1, 32'hA0, 4'b0001));
      tbl.push_back(mk(1, 4'hF, 1, 4'b0010, 1, 32'hA1, 4'b0010));
      tbl.push_back(mk(1, 4'hF, 1, 4'b0100, 1, 32'hA2, 4'b0100));
      tbl.push_back(mk(1, 4'hF, 1, 4'b1000, 1, 32'hA3, 4'b1000));
      tbl.push_back(mk(1, 4'hF, 1, 4'b0001, 1, 32'hA0, 4'b0001));
      tbl.push_back(mk(1, 4'hF, 1, 4'b0010, 1, 32'hA1, 4'b0010));
      // backpressure: A1 held, nothing accepted
      for (int i = 0; i < 5; i++)
         tbl.push_back(mk(1, 4'hF, 0, 4'h0, 1, 32'hA1, 4'b0010));
      tbl.push_back(mk(1, 4'hF, 1, 4'b0100, 1, 32'hA2, 4'b0100));
      // ptr=3 -> lone ch1 moves ptr to 2, then sparse 3/1 wrap
      tbl.push_back(mk(1, 4'b0010, 1, 4'b0010, 1, 32'hA1, 4'b0010));
      tbl.push_back(mk(1, 4'b1010, 1, 4'b1000, 1, 32'hA3, 4'b1000));
      tbl.push_back(mk(1, 4'b1010, 1, 4'b0010, 1, 32'hA1, 4'b0010));
      tbl.push_back(mk(1, 4'b1010, 1, 4'b1000, 1, 32'hA3, 4'b1000));
      // idle: valid drops, data/sel hold
      tbl.push_back(mk(1, 4'b0000, 1, 4'h0, 0, 32'hA3, 4'b1000));
      // ch0 loads, ptr=1; then reset mid-stream
      tbl.push_back(mk(1, 4'b0001, 1, 4'b0001, 1, 32'hA0, 4'b0001));
      tbl.push_back(mk(0, 4'b0101, 0, 4'h0, 0, 32'h0, 4'h0));
      tbl.push_back(mk(1, 4'b0101, 1, 4'b0001, 1, 32'hA0, 4'b0001));
      tbl.push_back(mk(1, 4'b0100, 0, 4'h0, 1, 32'hA0, 4'b0001));
      tbl.push_back(mk(1, 4'b0100, 1, 4'b0100, 1, 32'hA2, 4'b0100));

      foreach (tbl[i]) step(i, tbl[i]);

`ifdef MUX1HOT_RR_STAGE_PKT_LOCK_EN
      // reset, ch1 alone -> ptr=2, then 3-beat packet on ch2 vs ch0
      step(100, mk(0, 4'h0, 1, 4'h0, 0, 32'h0, 4'h0));
      step(101, mk(1, 4'b0010, 1, 4'b0010, 1, 32'hA1, 4'b0010));
      in_last = 4'b1011;
      step(102, mk(1, 4'b0101, 1, 4'b0100, 1, 32'hA2, 4'b0100));
      chk("out_last", 102, 32'(out_last), 32'd0);
      step(103, mk(1, 4'b0101, 1, 4'b0100, 1, 32'hA2, 4'b0100));
      in_last = 4'hF;
      step(104, mk(1, 4'b0101, 1, 4'b0100, 1, 32'hA2, 4'b0100));
      chk("out_last", 104, 32'(out_last), 32'd1);
      step(105, mk(1, 4'b0101, 1, 4'b0001, 1, 32'hA0, 4'b0001));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
